// File: rtl/key_debounce2.sv
// Two-key debouncer: per-key 2-flop sync plus a filter FSM
// producing a registered level and a one-cycle change strobe.
module key_debounce2_ch #(
  parameter int DEB_CNT = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic lvl,
  output logic pls
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    RELEASED,
    FILT_DOWN,
    PRESSED,
    FILT_UP
  } st_t;

  logic          s1;
  logic          s2;
  st_t           st;
  st_t           st_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          lvl_nx;
  logic          pls_nx;
  logic          cnt_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= RELEASED;
      cnt <= '0;
      lvl <= 1'b0;
      pls <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      lvl <= lvl_nx;
      pls <= pls_nx;
    end
  end

  assign cnt_top = (cnt == CMAX);

  always_comb begin
    st_nx = st;
    unique case (st)
      RELEASED:  if (!s2) st_nx = FILT_DOWN;
      FILT_DOWN: begin
        if (s2)           st_nx = RELEASED;
        else if (cnt_top) st_nx = PRESSED;
      end
      PRESSED:   if (s2) st_nx = FILT_UP;
      FILT_UP: begin
        if (!s2)          st_nx = PRESSED;
        else if (cnt_top) st_nx = RELEASED;
      end
      default:   st_nx = RELEASED;
    endcase
  end

  // Counter only runs while filtering a stable level; it
  // saturates so it can never wrap back into range.
  always_comb begin
    cnt_nx = '0;
    lvl_nx = lvl;
    pls_nx = 1'b0;
    unique case (1'b1)
      (st == FILT_DOWN) && !s2: begin
        cnt_nx = cnt_top ? cnt : cnt + 1'b1;
        if (cnt_top) begin
          lvl_nx = 1'b1;
          pls_nx = 1'b1;
        end
      end
      (st == FILT_UP) && s2: begin
        cnt_nx = cnt_top ? cnt : cnt + 1'b1;
        if (cnt_top) begin
          lvl_nx = 1'b0;
          pls_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

module key_debounce2 #(
  parameter int DEB_CNT = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_a_n,
  input  logic key_b_n,
  output logic a,
  output logic b,
  output logic a_pulse,
  output logic b_pulse
);

  key_debounce2_ch #(.DEB_CNT(DEB_CNT)) u_ch_a (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_a_n),
    .lvl   (a),
    .pls   (a_pulse)
  );

  key_debounce2_ch #(.DEB_CNT(DEB_CNT)) u_ch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_b_n),
    .lvl   (b),
    .pls   (b_pulse)
  );

endmodule

// File: tb/tb_key_debounce2.sv
// Directed bench for key_debounce2 with DEB_CNT = 4
// (accept latency 6 cycles from first sampling edge).
module tb_key_debounce2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_a_n = 1'b1;
  logic key_b_n = 1'b1;
  logic a;
  logic b;
  logic a_pulse;
  logic b_pulse;

  int nvec = 0;
  int nerr = 0;

  key_debounce2 #(.DEB_CNT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_a_n (key_a_n),
    .key_b_n (key_b_n),
    .a       (a),
    .b       (b),
    .a_pulse (a_pulse),
    .b_pulse (b_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %b want %b",
               tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ea,
                         input logic eap, input logic eb,
                         input logic ebp);
    chk({tag, ".a"}, a, ea);
    chk({tag, ".a_pulse"}, a_pulse, eap);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".b_pulse"}, b_pulse, ebp);
  endtask

  // Tick n times after an input change; levels move at tick 7.
  task automatic watch(input string tag, input logic a0,
                       input logic a1, input logic b0,
                       input logic b1, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk_all(tag,
              (i >= 7) ? a1 : a0, (i == 7) && (a0 != a1),
              (i >= 7) ? b1 : b0, (i == 7) && (b0 != b1));
    end
  endtask

  initial begin
    tick();
    tick();
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    key_a_n = 1'b0;
    watch("press_a", 1'b0, 1'b1, 1'b0, 1'b0, 10);

    key_b_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("glitch_b", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    key_b_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("glitch_b", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    key_a_n = 1'b1;
    watch("rel_a", 1'b1, 1'b0, 1'b0, 1'b0, 10);

    for (int i = 0; i < 4; i++) begin
      key_a_n = i[0];
      tick();
      chk_all("bounce_a", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    key_a_n = 1'b0;
    watch("bounce_a", 1'b0, 1'b1, 1'b0, 1'b0, 10);

    key_a_n = 1'b1;
    watch("rel_a2", 1'b1, 1'b0, 1'b0, 1'b0, 10);

    key_a_n = 1'b0;
    key_b_n = 1'b0;
    watch("both_dn", 1'b0, 1'b1, 1'b0, 1'b1, 10);
    key_a_n = 1'b1;
    key_b_n = 1'b1;
    watch("both_up", 1'b1, 1'b0, 1'b1, 1'b0, 10);

    key_a_n = 1'b0;
    watch("press_a3", 1'b0, 1'b1, 1'b0, 1'b0, 10);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    watch("rst_rel", 1'b0, 1'b1, 1'b0, 1'b0, 10);

    key_b_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("midfilt_b", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk_all("midfilt_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("midfilt_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    watch("held_both", 1'b0, 1'b1, 1'b0, 1'b1, 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/key_debounce2.md
KEY_DEBOUNCE2 -- requirements
Module: key_debounce2

Interface
REQ-001 The module SHALL have parameter DEB_CNT, default 240000, meaning the stable-sample count required to accept a key change (20 ms at 12 MHz).
REQ-002 The module SHALL have port clk, input, 1, meaning the system clock (12 MHz); all state SHALL be updated on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The module SHALL have port key_a_n, input, 1, meaning the raw, asynchronous, active-low key A (0 = pressed).
REQ-005 The module SHALL have port key_b_n, input, 1, meaning the raw, asynchronous, active-low key B (0 = pressed).
REQ-006 The module SHALL have port a, output, 1, meaning the debounced level of key A, active-high (1 = pressed); it feeds the comparator a input.
REQ-007 The module SHALL have port b, output, 1, meaning the debounced level of key B, active-high (1 = pressed); it feeds the comparator b input.
REQ-008 The module SHALL have port a_pulse, output, 1, meaning a one-cycle strobe on every accepted change of a.
REQ-009 The module SHALL have port b_pulse, output, 1, meaning a one-cycle strobe on every accepted change of b.

Function
REQ-010 Each channel SHALL pass its raw key through a 2-flop synchronizer before any other logic; both flops SHALL reset to 1 (released).
REQ-011 Each channel SHALL implement a 4-state FSM: RELEASED, FILT_DOWN, PRESSED, FILT_UP.
REQ-012 In RELEASED, a synchronized 0 SHALL move the FSM to FILT_DOWN with the counter cleared to 0.
REQ-013 In FILT_DOWN, the counter SHALL increment on each cycle the synchronized input is 0.
REQ-014 In FILT_DOWN, a synchronized 1 on any cycle SHALL return the FSM to RELEASED and clear the counter, with no output change.
REQ-015 In FILT_DOWN, when the counter equals DEB_CNT-1 and the synchronized input is still 0, the FSM SHALL enter PRESSED on the next edge; at that edge the level output SHALL go to 1 and the pulse output SHALL assert for exactly one cycle.
REQ-016 PRESSED and FILT_UP SHALL behave symmetrically to RELEASED and FILT_DOWN, with inverted input sense, driving the level output to 0 with a one-cycle pulse.
REQ-017 Acceptance latency SHALL be a fixed 2 + DEB_CNT cycles, counted from the first clock edge that samples the new raw value, for an input held stable throughout.
REQ-018 A glitch shorter than DEB_CNT cycles, measured at synchronizer output, SHALL produce no level change and no pulse.
REQ-019 The counter width SHALL be clog2(DEB_CNT), minimum 1; the counter SHALL saturate and never wrap.
REQ-020 Channels A and B SHALL be fully independent; simultaneous changes on both keys SHALL be accepted on the same cycle, with both pulses asserted together.
REQ-021 Pulse outputs SHALL never be high in two consecutive cycles.
REQ-022 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-023 While rst_n = 0, every FSM SHALL be in RELEASED, all counters SHALL be 0, synchronizers SHALL be 1, and a, b, a_pulse and b_pulse SHALL all be 0.
REQ-024 Reset asserted mid-filter or while PRESSED SHALL abort immediately, with no pulse generated.
REQ-025 After rst_n rises, a key already held low SHALL be accepted after the normal 2 + DEB_CNT latency.

Verification (DEB_CNT = 4 for simulation)
REQ-026 Reset with both keys = 1, then release reset -> a = b = 0 and pulses = 0 for 20 cycles.
REQ-027 Drive key_a_n 1->0 and hold it -> a rises exactly 6 cycles after the first sampling edge, a_pulse is high for 1 cycle, and b is unaffected.
REQ-028 Drive key_b_n low for 3 cycles, then high -> b stays 0 and b_pulse never asserts.
REQ-029 Drive key_a_n with bounce 0,1,0,1,0, then hold it at 0 -> a rises exactly once, 6 cycles after the last 1->0 edge, with a single a_pulse.
REQ-030 Drive both keys low on the same edge -> a and b rise on the same cycle and a_pulse and b_pulse coincide; release both -> both fall together with coincident pulses.
REQ-031 Hold a pressed (a = 1), then pulse rst_n low for 1 cycle -> a = 0 asynchronously with no pulse, and a returns to 1 after 6 cycles once rst_n is high.
